// File: rtl/multi_driver_cntrl_pkg.sv
// Shared types and register map for the multi-channel pattern driver control block.
// Optional runtime counter at 0x10C is built when MULTI_DRIVER_CNTRL_RUNTIME_EN is defined.
package multi_driver_cntrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_FROZEN = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } prog_state_e;

    localparam logic [31:0] REG_PUSH      = 32'h000;
    localparam logic [31:0] REG_CMD       = 32'h004;
    localparam logic [31:0] REG_ADDR_THR  = 32'h008;
    localparam logic [31:0] REG_VCTR_THR  = 32'h00C;
    localparam logic [31:0] REG_CH_SEL    = 32'h010;
    localparam logic [31:0] REG_CH_EN     = 32'h014;
    localparam logic [31:0] REG_IRQ_MASK  = 32'h018;
    localparam logic [31:0] REG_STATUS    = 32'h100;
    localparam logic [31:0] REG_STICKY    = 32'h104;
    localparam logic [31:0] REG_FILL_BASE = 32'h108;
    localparam logic [31:0] REG_RUNTIME   = 32'h10C;

    localparam int CMD_RUN    = 0;
    localparam int CMD_END    = 1;
    localparam int CMD_ABORT  = 2;
    localparam int CMD_FREEZE = 3;
    localparam int CMD_RESUME = 4;

endpackage

// File: rtl/multi_driver_cntrl_if.sv
// Register-port bus between the AXI-lite slave adapter and the driver control block.
interface multi_driver_cntrl_if;
    logic [31:0] slave_awaddr;
    logic [31:0] slave_araddr;
    logic        slave_wr;
    logic        slave_rd;
    logic [31:0] slave_data_in;
    logic [31:0] slave_data_out;

    modport master (
        output slave_awaddr, slave_araddr, slave_wr, slave_rd, slave_data_in,
        input  slave_data_out
    );

    modport slave (
        input  slave_awaddr, slave_araddr, slave_wr, slave_rd, slave_data_in,
        output slave_data_out
    );
endinterface

// File: rtl/driver_prog_fsm.sv
// Program state machine with start/end pulses, sticky error capture and registered irq.
module driver_prog_fsm
    import multi_driver_cntrl_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_wr_i,
    input  logic [4:0]        cmd_i,
    input  logic [NUM_CH-1:0] err_i,
    input  logic              drop_i,
    input  logic              sticky_wr_i,
    input  logic [NUM_CH:0]   sticky_clr_i,
    input  logic [NUM_CH:0]   irq_mask_i,
    output prog_state_e       state_o,
    output logic              run_program_o,
    output logic              end_program_o,
    output logic              active_program_o,
    output logic              freeze_program_o,
    output logic [NUM_CH:0]   sticky_o,
    output logic              irq_o
);

    prog_state_e       state_q, state_d;
    logic [NUM_CH:0]   sticky_q, sticky_d;
    logic              run_q, end_q, active_q, freeze_q, irq_q;
    logic              inProg, doRun, doEnd, doAbort, doFreeze, doResume;

    always_comb begin
        inProg   = (state_q == ST_ACTIVE) || (state_q == ST_FROZEN);
        doRun    = cmd_wr_i && cmd_i[CMD_RUN];
        doEnd    = cmd_wr_i && cmd_i[CMD_END];
        doAbort  = cmd_wr_i && cmd_i[CMD_ABORT];
        doFreeze = cmd_wr_i && cmd_i[CMD_FREEZE];
        doResume = cmd_wr_i && cmd_i[CMD_RESUME];
        state_d  = state_q;
        if (doAbort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_START:  state_d = ST_ACTIVE;
                ST_ACTIVE: begin
                    if (|err_i)        state_d = ST_ERROR;
                    else if (doEnd)    state_d = ST_DONE;
                    else if (doFreeze) state_d = ST_FROZEN;
                end
                ST_FROZEN: begin
                    if (|err_i)        state_d = ST_ERROR;
                    else if (doEnd)    state_d = ST_DONE;
                    else if (doResume) state_d = ST_ACTIVE;
                end
                default: begin
                    if (doRun) state_d = ST_START;
                end
            endcase
        end
    end

    // Clear first and set last so a same-cycle set beats W1C.
    always_comb begin
        sticky_d = sticky_q;
        if (state_q == ST_START) sticky_d = '0;
        if (sticky_wr_i) sticky_d = sticky_d & ~sticky_clr_i;
        if (inProg) sticky_d[NUM_CH-1:0] = sticky_d[NUM_CH-1:0] | err_i;
        if (drop_i) sticky_d[NUM_CH] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sticky_q <= '0;
            run_q    <= 1'b0;
            end_q    <= 1'b0;
            active_q <= 1'b0;
            freeze_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            run_q    <= (state_d == ST_START);
            end_q    <= inProg && (state_d == ST_DONE);
            active_q <= (state_d == ST_ACTIVE) || (state_d == ST_FROZEN);
            freeze_q <= (state_d == ST_FROZEN);
            irq_q    <= |(sticky_q & irq_mask_i);
        end
    end

    assign state_o          = state_q;
    assign run_program_o    = run_q;
    assign end_program_o    = end_q;
    assign active_program_o = active_q;
    assign freeze_program_o = freeze_q;
    assign sticky_o         = sticky_q;
    assign irq_o            = irq_q;

endmodule

// File: rtl/multi_driver_cntrl.sv
// Register file and read mux for the multi-channel pattern driver; FSM lives in driver_prog_fsm.
// Define MULTI_DRIVER_CNTRL_RUNTIME_EN to build the ACTIVE-cycle counter at 0x10C.
module multi_driver_cntrl
    import multi_driver_cntrl_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 16,
    parameter logic [15:0] ADDR_THR_RST = 16'd820,
    parameter logic [15:0] VCTR_THR_RST = 16'd7500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multi_driver_cntrl_if.slave     bus,
    output logic [31:0]             addr_fifo_din_o,
    output logic [NUM_CH-1:0]       addr_fifo_wr_o,
    input  logic [NUM_CH-1:0]       addr_fifo_full_i,
    input  logic [NUM_CH-1:0]       addr_fifo_empty_i,
    input  logic [NUM_CH-1:0]       addr_fifo_overrun_i,
    input  logic [NUM_CH-1:0]       addr_fifo_underrun_i,
    input  logic [NUM_CH-1:0]       vctr_fifo_full_i,
    input  logic [NUM_CH-1:0]       vctr_fifo_empty_i,
    input  logic [NUM_CH-1:0]       vctr_fifo_overrun_i,
    input  logic [NUM_CH-1:0]       vctr_fifo_underrun_i,
    input  logic [NUM_CH*CNT_W-1:0] words_in_addr_fifo_i,
    input  logic [NUM_CH*CNT_W-1:0] words_in_vctr_fifo_i,
    output logic [15:0]             addr_fifo_threshold_o,
    output logic [15:0]             vector_fifo_threshold_o,
    output logic [NUM_CH-1:0]       ch_enable_o,
    output logic                    run_program_o,
    output logic                    active_program_o,
    output logic                    freeze_program_o,
    output logic                    end_program_o,
    output logic                    irq_o
);

    localparam logic [4:0] NUM_CH5 = 5'(NUM_CH);
    localparam logic [3:0] CH_MAX  = 4'(NUM_CH - 1);

    logic [31:0]       din_q, rdata_q, rdata_d;
    logic [NUM_CH-1:0] wr_q, chEn_q, pushOh, errCh;
    logic [15:0]       addrThr_q, vctrThr_q;
    logic [3:0]        chSel_q;
    logic [NUM_CH:0]   irqMask_q, sticky;
    logic              selFull, wrPush, irq;
    prog_state_e       state;

    assign wrPush = bus.slave_wr && (bus.slave_awaddr == REG_PUSH);
    assign errCh  = chEn_q & (addr_fifo_overrun_i | addr_fifo_underrun_i |
                              vctr_fifo_overrun_i | vctr_fifo_underrun_i);

    always_comb begin
        pushOh  = '0;
        selFull = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chSel_q == 4'(i)) begin
                pushOh[i] = 1'b1;
                selFull   = addr_fifo_full_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q     <= '0;
            wr_q      <= '0;
            addrThr_q <= ADDR_THR_RST;
            vctrThr_q <= VCTR_THR_RST;
            chSel_q   <= '0;
            chEn_q    <= '1;
            irqMask_q <= '0;
            rdata_q   <= '0;
        end else begin
            wr_q <= '0;
            if (bus.slave_wr) begin
                case (bus.slave_awaddr)
                    REG_PUSH: begin
                        if (!selFull) begin
                            wr_q  <= pushOh;
                            din_q <= bus.slave_data_in;
                        end
                    end
                    REG_ADDR_THR: addrThr_q <= bus.slave_data_in[15:0];
                    REG_VCTR_THR: vctrThr_q <= bus.slave_data_in[15:0];
                    REG_CH_SEL:   chSel_q   <= ({1'b0, bus.slave_data_in[3:0]} >= NUM_CH5) ?
                                               CH_MAX : bus.slave_data_in[3:0];
                    REG_CH_EN:    chEn_q    <= bus.slave_data_in[NUM_CH-1:0];
                    REG_IRQ_MASK: irqMask_q <= bus.slave_data_in[NUM_CH:0];
                    default: ;
                endcase
            end
            if (bus.slave_rd) rdata_q <= rdata_d;
        end
    end

`ifdef MULTI_DRIVER_CNTRL_RUNTIME_EN
    logic [31:0] runtime_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            runtime_q <= '0;
        end else if (state == ST_START) begin
            runtime_q <= '0;
        end else if ((state == ST_ACTIVE) && (runtime_q != 32'hFFFF_FFFF)) begin
            runtime_q <= runtime_q + 32'd1;
        end
    end
`endif

    // The runtime slot at 0x10C overlays the channel-1 fill-level window.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.slave_araddr == REG_FILL_BASE + 32'(4 * i)) begin
                rdata_d = {16'(words_in_vctr_fifo_i[i*CNT_W +: CNT_W]),
                           16'(words_in_addr_fifo_i[i*CNT_W +: CNT_W])};
            end
        end
        case (bus.slave_araddr)
            REG_PUSH:     rdata_d = din_q;
            REG_ADDR_THR: rdata_d = {16'b0, addrThr_q};
            REG_VCTR_THR: rdata_d = {16'b0, vctrThr_q};
            REG_CH_SEL:   rdata_d = {28'b0, chSel_q};
            REG_CH_EN:    rdata_d = 32'(chEn_q);
            REG_IRQ_MASK: rdata_d = 32'(irqMask_q);
            REG_STATUS:   rdata_d = {12'b0, |addr_fifo_full_i, |addr_fifo_empty_i,
                                     |vctr_fifo_full_i, |vctr_fifo_empty_i,
                                     12'b0, irq, state};
            REG_STICKY:   rdata_d = 32'(sticky);
`ifdef MULTI_DRIVER_CNTRL_RUNTIME_EN
            REG_RUNTIME:  rdata_d = runtime_q;
`else
            REG_RUNTIME:  rdata_d = '0;
`endif
            default: ;
        endcase
    end

    driver_prog_fsm #(.NUM_CH(NUM_CH)) u_fsm (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_wr_i         (bus.slave_wr && (bus.slave_awaddr == REG_CMD)),
        .cmd_i            (bus.slave_data_in[4:0]),
        .err_i            (errCh),
        .drop_i           (wrPush && selFull),
        .sticky_wr_i      (bus.slave_wr && (bus.slave_awaddr == REG_STICKY)),
        .sticky_clr_i     (bus.slave_data_in[NUM_CH:0]),
        .irq_mask_i       (irqMask_q),
        .state_o          (state),
        .run_program_o    (run_program_o),
        .end_program_o    (end_program_o),
        .active_program_o (active_program_o),
        .freeze_program_o (freeze_program_o),
        .sticky_o         (sticky),
        .irq_o            (irq)
    );

    assign bus.slave_data_out      = rdata_q;
    assign addr_fifo_din_o         = din_q;
    assign addr_fifo_wr_o          = wr_q;
    assign addr_fifo_threshold_o   = addrThr_q;
    assign vector_fifo_threshold_o = vctrThr_q;
    assign ch_enable_o             = chEn_q;
    assign irq_o                   = irq;

endmodule

// File: tb/tb_multi_driver_cntrl.sv
// Directed-plus-random bench for multi_driver_cntrl with a rule-level model of the program flow.
// Runtime counter checks are compiled when MULTI_DRIVER_CNTRL_RUNTIME_EN is defined.
module tb_multi_driver_cntrl;
    import multi_driver_cntrl_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_driver_cntrl_if busIf ();

    logic [31:0]             addrFifoDin;
    logic [NUM_CH-1:0]       addrFifoWr;
    logic [NUM_CH-1:0]       aFull, aEmpty, aOver, aUnder, vFull, vEmpty, vOver, vUnder;
    logic [NUM_CH*CNT_W-1:0] wordsAddr, wordsVctr;
    logic [15:0]             addrThr, vctrThr;
    logic [NUM_CH-1:0]       chEnable;
    logic                    runProgram, activeProgram, freezeProgram, endProgram, irq;

    multi_driver_cntrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .bus                     (busIf),
        .addr_fifo_din_o         (addrFifoDin),
        .addr_fifo_wr_o          (addrFifoWr),
        .addr_fifo_full_i        (aFull),
        .addr_fifo_empty_i       (aEmpty),
        .addr_fifo_overrun_i     (aOver),
        .addr_fifo_underrun_i    (aUnder),
        .vctr_fifo_full_i        (vFull),
        .vctr_fifo_empty_i       (vEmpty),
        .vctr_fifo_overrun_i     (vOver),
        .vctr_fifo_underrun_i    (vUnder),
        .words_in_addr_fifo_i    (wordsAddr),
        .words_in_vctr_fifo_i    (wordsVctr),
        .addr_fifo_threshold_o   (addrThr),
        .vector_fifo_threshold_o (vctrThr),
        .ch_enable_o             (chEnable),
        .run_program_o           (runProgram),
        .active_program_o        (activeProgram),
        .freeze_program_o        (freezeProgram),
        .end_program_o           (endProgram),
        .irq_o                   (irq)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Program-flow model: states are plain numbers 0..5 following the command rules.
    int          mState;
    logic [31:0] mLastPush;

    function automatic int nextState(input int s, input logic [4:0] c);
        if (c[2]) return 0;
        if (s == 2 || s == 3) begin
            if (c[1]) return 4;
            if (s == 2 && c[3]) return 3;
            if (s == 3 && c[4]) return 2;
            return s;
        end
        if (s == 1) return 2;
        if (c[0]) return 1;
        return s;
    endfunction

    function automatic logic [31:0] statusWord(input int st, input logic irqBit);
        return {12'b0, |aFull, |aEmpty, |vFull, |vEmpty, 12'b0, irqBit, 3'(st)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        busIf.slave_awaddr  = addr;
        busIf.slave_data_in = data;
        busIf.slave_wr      = 1'b1;
        @(negedge clk);
        busIf.slave_wr      = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        busIf.slave_araddr = addr;
        busIf.slave_rd     = 1'b1;
        @(negedge clk);
        busIf.slave_rd     = 1'b0;
        data = busIf.slave_data_out;
    endtask

    initial begin
        logic [31:0] rd, val;
        logic [4:0]  cmd;
        int          sel, prev;

        rst_n = 1'b0;
        busIf.slave_awaddr = '0; busIf.slave_araddr = '0; busIf.slave_data_in = '0;
        busIf.slave_wr = 1'b0; busIf.slave_rd = 1'b0;
        aFull = '0; aEmpty = '0; aOver = '0; aUnder = '0;
        vFull = '0; vEmpty = '0; vOver = '0; vUnder = '0;
        wordsAddr = '0; wordsVctr = '0;
        mState = 0; mLastPush = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_wr",       32'(addrFifoWr), 32'h0);
        checkOutput("reset_din",      addrFifoDin, 32'h0);
        checkOutput("reset_addr_thr", 32'(addrThr), 32'd820);
        checkOutput("reset_vctr_thr", 32'(vctrThr), 32'd7500);
        checkOutput("reset_ch_en",    32'(chEnable), 32'hF);
        checkOutput("reset_pulses",   32'({runProgram, activeProgram, freezeProgram, endProgram, irq}), 32'h0);
        checkOutput("reset_rdata",    busIf.slave_data_out, 32'h0);
        rst_n = 1'b1;

        busRead(REG_ADDR_THR, rd); checkOutput("rd_addr_thr", rd, 32'd820);
        busRead(REG_VCTR_THR, rd); checkOutput("rd_vctr_thr", rd, 32'd7500);
        busRead(REG_STATUS, rd);   checkOutput("rd_status_idle", rd, statusWord(0, 1'b0));
        busRead(REG_CMD, rd);      checkOutput("rd_cmd_zero", rd, 32'h0);

        val = 32'($urandom);
        applyStimulus(REG_ADDR_THR, val);
        checkOutput("addr_thr_out", 32'(addrThr), {16'b0, val[15:0]});
        val = 32'($urandom);
        applyStimulus(REG_VCTR_THR, val);
        busRead(REG_VCTR_THR, rd); checkOutput("vctr_thr_rd", rd, {16'b0, val[15:0]});

        // Random channel selects, including out-of-range values that must clamp.
        for (int k = 0; k < 4; k++) begin
            sel = (k == 0) ? 15 : int'($urandom_range(0, 15));
            applyStimulus(REG_CH_SEL, 32'(sel));
            if (sel > NUM_CH - 1) sel = NUM_CH - 1;
            busRead(REG_CH_SEL, rd); checkOutput("ch_sel_clamp", rd, 32'(sel));
            val = 32'($urandom);
            applyStimulus(REG_PUSH, val);
            mLastPush = val;
            checkOutput("push_strobe", 32'(addrFifoWr), 32'(1 << sel));
            checkOutput("push_din", addrFifoDin, mLastPush);
            @(negedge clk);
            checkOutput("push_strobe_1cyc", 32'(addrFifoWr), 32'h0);
        end

        applyStimulus(REG_CH_SEL, 32'd2);
        applyStimulus(REG_PUSH, 32'hDEAD_BEEF);
        mLastPush = 32'hDEAD_BEEF;
        checkOutput("push_ch2_strobe", 32'(addrFifoWr), 32'h4);
        checkOutput("push_ch2_din", addrFifoDin, 32'hDEAD_BEEF);
        aFull = 4'b0100;
        applyStimulus(REG_PUSH, 32'(~$urandom));
        checkOutput("drop_no_strobe", 32'(addrFifoWr), 32'h0);
        busRead(REG_PUSH, rd);   checkOutput("drop_last_push", rd, mLastPush);
        busRead(REG_STICKY, rd); checkOutput("drop_sticky", rd, 32'(1 << NUM_CH));
        checkOutput("drop_irq_masked", 32'(irq), 32'h0);

        {aFull, aEmpty, vFull, vEmpty} = 16'($urandom);
        busRead(REG_STATUS, rd); checkOutput("status_flags", rd, statusWord(0, 1'b0));
        aFull = '0; aEmpty = '0; vFull = '0; vEmpty = '0;

        wordsAddr = 64'({$urandom, $urandom});
        wordsVctr = 64'({$urandom, $urandom});
        for (int i = 0; i < NUM_CH; i++) begin
            if (i == 1) continue;
            busRead(REG_FILL_BASE + 32'(4 * i), rd);
            checkOutput("fill_level", rd, {wordsVctr[i*16 +: 16], wordsAddr[i*16 +: 16]});
        end
        busRead(32'h200, rd); checkOutput("unmapped_zero", rd, 32'h0);
`ifndef MULTI_DRIVER_CNTRL_RUNTIME_EN
        busRead(REG_RUNTIME, rd); checkOutput("runtime_absent", rd, 32'h0);
`endif

        // Directed program sequence run -> freeze -> resume -> end.
        applyStimulus(REG_CMD, 32'h1);
        checkOutput("run_pulse", 32'(runProgram), 32'h1);
        @(negedge clk);
        checkOutput("run_pulse_end", 32'(runProgram), 32'h0);
        busRead(REG_STATUS, rd); checkOutput("state_active", rd, statusWord(2, 1'b0));
        applyStimulus(REG_CMD, 32'h8);
        checkOutput("freeze_out", 32'({activeProgram, freezeProgram}), 32'h3);
        busRead(REG_STATUS, rd); checkOutput("state_frozen", rd, statusWord(3, 1'b0));
        applyStimulus(REG_CMD, 32'h10);
        busRead(REG_STATUS, rd); checkOutput("state_resumed", rd, statusWord(2, 1'b0));
        applyStimulus(REG_CMD, 32'h2);
        checkOutput("end_pulse", 32'(endProgram), 32'h1);
        @(negedge clk);
        checkOutput("end_pulse_end", 32'(endProgram), 32'h0);
        busRead(REG_STATUS, rd); checkOutput("state_done", rd, statusWord(4, 1'b0));
        mState = 4;

        // Random command words against the rule model.
        for (int k = 0; k < 24; k++) begin
            cmd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) cmd[2] = 1'b0;
            prev   = mState;
            mState = nextState(mState, cmd);
            applyStimulus(REG_CMD, 32'(cmd));
            checkOutput("rand_run_pulse", 32'(runProgram), 32'(mState == 1));
            checkOutput("rand_end_pulse", 32'(endProgram), 32'((prev == 2 || prev == 3) && mState == 4));
            if (mState == 1) mState = 2;
            @(negedge clk);
            checkOutput("rand_active", 32'({activeProgram, freezeProgram}),
                        32'({mState == 2 || mState == 3, mState == 3}));
            busRead(REG_STATUS, rd); checkOutput("rand_state", rd, statusWord(mState, 1'b0));
        end

        // Channel error while ACTIVE with the interrupt unmasked for channel 1.
        applyStimulus(REG_CMD, 32'h4);
        applyStimulus(REG_IRQ_MASK, 32'h2);
        applyStimulus(REG_CMD, 32'h1);
        @(negedge clk);
        vUnder = 4'b0010;
        @(negedge clk);
        vUnder = '0;
        checkOutput("err_irq_lag", 32'(irq), 32'h0);
        @(negedge clk);
        checkOutput("err_irq", 32'(irq), 32'h1);
        busRead(REG_STATUS, rd); checkOutput("err_state", rd, statusWord(5, 1'b1));
        busRead(REG_STICKY, rd); checkOutput("err_sticky", rd, 32'h2);
        applyStimulus(REG_STICKY, 32'h2);
        checkOutput("w1c_irq_lag", 32'(irq), 32'h1);
        @(negedge clk);
        checkOutput("w1c_irq_drop", 32'(irq), 32'h0);
        busRead(REG_STICKY, rd); checkOutput("w1c_sticky", rd, 32'h0);

        // Same flag on a disabled channel must be ignored.
        applyStimulus(REG_CH_EN, 32'hD);
        checkOutput("ch_en_out", 32'(chEnable), 32'hD);
        applyStimulus(REG_CMD, 32'h1);
        @(negedge clk);
        vUnder = 4'b0010;
        repeat (2) @(negedge clk);
        vUnder = '0;
        busRead(REG_STATUS, rd); checkOutput("dis_state", rd, statusWord(2, 1'b0));
        busRead(REG_STICKY, rd); checkOutput("dis_sticky", rd, 32'h0);

        applyStimulus(REG_CMD, 32'h7);
        checkOutput("abort_no_end", 32'(endProgram), 32'h0);
        busRead(REG_STATUS, rd); checkOutput("abort_state", rd, statusWord(0, 1'b0));
        checkOutput("abort_inactive", 32'(activeProgram), 32'h0);

`ifdef MULTI_DRIVER_CNTRL_RUNTIME_EN
        applyStimulus(REG_CMD, 32'h1);
        repeat (99) @(negedge clk);
        applyStimulus(REG_CMD, 32'h8);
        busRead(REG_RUNTIME, rd); checkOutput("runtime_100", rd, 32'd100);
        repeat (10) @(negedge clk);
        busRead(REG_RUNTIME, rd); checkOutput("runtime_hold", rd, 32'd100);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/multi_driver_cntrl.md
Name: multi_driver_cntrl

Overview:
Register-mapped control and status block for a multi-channel pattern driver.
- Generalises the single-channel driver control to NUM_CH address/vector FIFO pairs, shared behind one slave register port.
- Adds an explicit program state machine, per-channel sticky error capture with write-1-to-clear, and a maskable interrupt.
- Sits between the AXI-lite slave adapter and the per-channel address/vector FIFOs and sequencers.

Parameters:
NUM_CH, 4, number of driver channels (1..16)
CNT_W, 16, width of cycle and word-count inputs per channel
ADDR_THR_RST, 820, reset value of the address FIFO threshold
VCTR_THR_RST, 7500, reset value of the vector FIFO threshold

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
slave_awaddr  in  32  write address
slave_araddr  in  32  read address
slave_wr  in  1  write strobe, one cycle per access
slave_rd  in  1  read strobe, one cycle per access
slave_data_in  in  32  write data
slave_data_out  out  32  read data, registered
addr_fifo_din  out  32  push data, shared by all channels
addr_fifo_wr  out  NUM_CH  one-hot push strobe
addr_fifo_full/empty/overrun/underrun  in  NUM_CH each  per-channel address FIFO flags
vctr_fifo_full/empty/overrun/underrun  in  NUM_CH each  per-channel vector FIFO flags
words_in_addr_fifo  in  NUM_CH*CNT_W  packed fill levels, channel 0 in the LSBs
words_in_vctr_fifo  in  NUM_CH*CNT_W  packed fill levels, channel 0 in the LSBs
addr_fifo_threshold  out  16  shared threshold
vector_fifo_threshold  out  16  shared threshold
ch_enable  out  NUM_CH  channel enable mask
run_program  out  1  one-cycle start pulse
active_program  out  1  high while in ACTIVE or FROZEN
freeze_program  out  1  high while in FROZEN
end_program  out  1  one-cycle pulse on ACTIVE->DONE
irq  out  1  registered interrupt

Behaviour:
Reset: all outputs 0 except addr_fifo_threshold=ADDR_THR_RST and vector_fifo_threshold=VCTR_THR_RST; ch_enable reset value is all ones; state IDLE.

Register map (writes take effect next cycle; reads have 1-cycle latency; slave_data_out holds its value when slave_rd=0; unmapped reads return 0):
- 0x000 W: push slave_data_in to the channel selected by CH_SEL. addr_fifo_wr[CH_SEL]=1 for one cycle. Push is dropped if addr_fifo_full[CH_SEL]=1; the drop sets sticky bit DROP. Read returns the last pushed word.
- 0x004 CMD, write-only pulses: bit0 run, bit1 end, bit2 abort, bit3 freeze, bit4 resume. Reads return 0.
- 0x008 addr threshold [15:0]; 0x00C vector threshold [15:0].
- 0x010 CH_SEL [3:0]. Values >= NUM_CH are clamped to NUM_CH-1.
- 0x014 ch_enable [NUM_CH-1:0].
- 0x018 IRQ_MASK [NUM_CH:0]. Bit NUM_CH masks DROP.
- 0x100 STATUS: [2:0]=state, [3]=irq, [31:16]=OR of all full/empty flags grouped as {aF,aE,vF,vE}, padded with zeros.
- 0x104 STICKY [NUM_CH:0]: per-channel error plus DROP. Write-1-to-clear.
- 0x108+4*i: {words_in_vctr_fifo[i], words_in_addr_fifo[i]}, truncated or zero-padded to 16 bits each, i < NUM_CH.

State machine: IDLE=0, START=1, ACTIVE=2, FROZEN=3, DONE=4, ERROR=5.
- IDLE/DONE/ERROR + run -> START. START lasts exactly one cycle: clears STICKY and pulses run_program. START -> ACTIVE.
- ACTIVE + freeze -> FROZEN; FROZEN + resume -> ACTIVE.
- ACTIVE or FROZEN + end -> DONE (end_program pulses for 1 cycle).
- abort -> IDLE from any state.
- ACTIVE or FROZEN with any enabled channel showing any overrun/underrun flag -> ERROR; that channel's sticky bit is set the same cycle.

Priority within one CMD write: abort > end > freeze/resume > run. run is ignored in ACTIVE or FROZEN.
Sticky set and W1C clear on the same bit in the same cycle: set wins.
irq is registered: irq <= |(STICKY & IRQ_MASK), 1-cycle lag.
Asynchronous reset mid-program forces IDLE immediately; pushes in flight are lost.

Optional Feature:
MULTI_DRIVER_CNTRL_RUNTIME_EN
- With the macro: a 32-bit cycle counter at 0x10C. Cleared in START, increments while ACTIVE, holds in FROZEN/DONE/ERROR, saturates at 0xFFFF_FFFF.
- Without the macro: 0x10C reads 0 and no counter logic is built.

Decomposition:
- Package multi_driver_cntrl_pkg: state enum, register offset localparams, CMD bit indices.
- One sub-module, driver_prog_fsm: state machine, run/end pulses, sticky/irq logic.
- The register file and read mux stay in the top module.

Test Plan:
- Reset, then read 0x008/0x00C -> 820/7500; read 0x100 -> state 0; irq=0.
- Write CH_SEL=2, write 0xDEAD_BEEF to 0x000 -> addr_fifo_wr=4'b0100 for 1 cycle, addr_fifo_din=0xDEADBEEF. Repeat with full[2]=1 -> no strobe, STICKY bit NUM_CH set.
- CMD=0x1 -> run_program pulse 1 cycle, state 2 two cycles after the write. CMD=0x8 -> state 3, freeze_program=1. CMD=0x10 -> state 2. CMD=0x2 -> end_program pulse, state 4.
- ACTIVE, vctr_fifo_underrun[1]=1 with ch_enable[1]=1 -> state 5, STICKY=0x02, irq=1 one cycle later if mask bit1 set. Write 0x104=0x02 -> STICKY=0, irq drops. Same flag with ch_enable[1]=0 -> no error.
- CMD=0x7 (run+end+abort) while ACTIVE -> state 0, no end_program pulse.
- With MULTI_DRIVER_CNTRL_RUNTIME_EN: run, then freeze after 100 ACTIVE cycles -> 0x10C reads 100 and holds while frozen.
